cplx_alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one multi-cycle complex ALU among 2**IDW requesters. Each requester submits an 18-bit op word {opcode[1:0], a, b, c, d} through a valid/ready handshake. The block issues one operation at a time to the ALU over a start/done interface and returns the signed 8-bit real and imaginary results tagged with the requester id. It sits between the requester ports and the complex ALU; the ALU itself stays outside this block.

---
 rtl/cplx_alu_arbiter.sv | 133 +++++++++++++
 tb/tb_cplx_alu_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cplx_alu_arbiter.sv
// Round-robin front end for a shared multi-cycle complex ALU.
// Grants one requester at a time and launches its op on the ALU.
// Returns the ALU result, or an error for an illegal opcode or a timeout,
// tagged with the requester id.
module cplx_alu_arbiter #(
  parameter int IDW     = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2**IDW-1:0]        req_valid,
  input  logic [18*(2**IDW)-1:0]   req_data,
  output logic [2**IDW-1:0]        req_ready,
  output logic                     alu_start,
  output logic [17:0]              alu_data,
  input  logic                     alu_done,
  input  logic [7:0]               alu_result_r,
  input  logic [7:0]               alu_result_i,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [7:0]               rsp_result_r,
  output logic [7:0]               rsp_result_i,
  output logic                     rsp_error,
  output logic                     busy
);

  localparam int NREQ = 2**IDW;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state, next_state;
  logic [IDW-1:0]   last_grant;
  logic [17:0]      op_q;
  logic [7:0]       timer;
  logic             grant_valid;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   scan_id;
  logic [17:0]      grant_word;
  logic             grant_illegal;
  logic             timeout_hit;

  // Round-robin search: first valid requester after last_grant, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    grant_valid = 1'b0;
    grant_id    = '0;
    scan_id     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      scan_id = last_grant + IDW'(i);
      if (!grant_valid && req_valid[scan_id]) begin
        grant_valid = 1'b1;
        grant_id    = scan_id;
      end
    end
  end

  assign grant_word    = req_data[18*int'(grant_id) +: 18];
  assign grant_illegal = (grant_word[17:16] == 2'b11);
  // The timer counts completed WAIT cycles; this is the last allowed one.
  assign timeout_hit   = (timer == 8'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic; alu_done takes priority over the timeout.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (grant_valid) next_state = grant_illegal ? S_RESP : S_ISSUE;
      S_ISSUE: next_state = S_WAIT;
      S_WAIT:  if (alu_done || timeout_hit) next_state = S_RESP;
      S_RESP:  if (rsp_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // One-hot accept only in IDLE, and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && !rst && grant_valid) req_ready[grant_id] = 1'b1;
  end

  assign alu_start = (state == S_ISSUE);
  assign alu_data  = (state == S_ISSUE || state == S_WAIT) ? op_q : 18'd0;
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);

  // Op latch, WAIT timer, response capture and round-robin pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant   <= IDW'(NREQ - 1);
      op_q         <= '0;
      timer        <= '0;
      rsp_id       <= '0;
      rsp_result_r <= '0;
      rsp_result_i <= '0;
      rsp_error    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            op_q         <= grant_word;
            rsp_id       <= grant_id;
            rsp_error    <= grant_illegal;
            rsp_result_r <= '0;
            rsp_result_i <= '0;
          end
        end
        S_ISSUE: timer <= '0;
        S_WAIT: begin
          timer <= timer + 8'd1;
          if (alu_done) begin
            rsp_result_r <= alu_result_r;
            rsp_result_i <= alu_result_i;
            rsp_error    <= 1'b0;
          end else if (timeout_hit) begin
            rsp_result_r <= '0;
            rsp_result_i <= '0;
            rsp_error    <= 1'b1;
          end
        end
        S_RESP:  if (rsp_ready) last_grant <= rsp_id;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cplx_alu_arbiter.sv
// Self-checking bench for cplx_alu_arbiter. The bench plays the ALU and
// predicts grants and responses from a round-robin model.
module tb_cplx_alu_arbiter;

  localparam int IDW     = 2;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [18*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              alu_start;
  logic [17:0]       alu_data;
  logic              alu_done;
  logic [7:0]        alu_result_r;
  logic [7:0]        alu_result_i;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_result_r;
  logic [7:0]        rsp_result_i;
  logic              rsp_error;
  logic              busy;

  int n_pass  = 0;
  int n_total = 0;
  int model_last;

  cplx_alu_arbiter #(.IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .alu_start    (alu_start),
    .alu_data     (alu_data),
    .alu_done     (alu_done),
    .alu_result_r (alu_result_r),
    .alu_result_i (alu_result_i),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result_r (rsp_result_r),
    .rsp_result_i (rsp_result_i),
    .rsp_error    (rsp_error),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case some wait is never satisfied.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Round-robin reference: first valid index after the previous grant.
  function automatic int model_pick(input logic [NREQ-1:0] v);
    for (int i = 1; i <= NREQ; i++)
      if (v[(model_last + i) % NREQ]) return (model_last + i) % NREQ;
    return -1;
  endfunction

  function automatic logic [17:0] rand_word(input bit legal);
    logic [17:0] w;
    w = 18'($urandom);
    if (legal && w[17:16] == 2'b11) w[17:16] = 2'($urandom_range(0, 2));
    return w;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_alu_start"}, alu_start, 0);
    check({tag, "_alu_data"},  alu_data, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_id"},    rsp_id, 0);
    check({tag, "_rsp_r"},     rsp_result_r, 0);
    check({tag, "_rsp_i"},     rsp_result_i, 0);
    check({tag, "_rsp_error"}, rsp_error, 0);
    check({tag, "_busy"},      busy, 0);
  endtask

  // One complete transaction. d = cycle (counted from alu_start) in which the
  // bench ALU pulses done; hold = cycles rsp_ready stays low in RESP.
  task automatic do_op(input logic [NREQ-1:0] valid, input logic [18*NREQ-1:0] data,
                       input int d, input logic [7:0] rr, input logic [7:0] ri,
                       input int hold);
    int          k;
    int          c;
    int          resp_at;
    logic [17:0] word;
    logic        illegal;
    logic        exp_err;
    logic [7:0]  er;
    logic [7:0]  ei;
    req_valid = valid;
    req_data  = data;
    rsp_ready = 1'b0;
    alu_done  = 1'b0;
    #1;
    k = model_pick(valid);
    check("grant", req_ready, 32'(1) << k);
    word    = data[k*18 +: 18];
    illegal = (word[17:16] == 2'b11);
    cyc();
    c = 0;
    check("accept_alu_start", alu_start, !illegal);
    check("accept_busy", busy, 1);
    check("accept_req_ready", req_ready, 0);
    if (!illegal) check("issue_alu_data", alu_data, word);
    resp_at = illegal ? 0 : ((d <= TIMEOUT) ? d + 1 : TIMEOUT + 1);
    exp_err = illegal || (d > TIMEOUT);
    er      = exp_err ? 8'd0 : rr;
    ei      = exp_err ? 8'd0 : ri;
    while (rsp_valid !== 1'b1 && c < 64) begin
      alu_done     = (c == d);
      alu_result_r = rr;
      alu_result_i = ri;
      cyc();
      c++;
      if (rsp_valid !== 1'b1) begin
        check("wait_req_ready", req_ready, 0);
        check("wait_alu_start", alu_start, 0);
        check("wait_alu_data", alu_data, word);
      end
    end
    alu_done = 1'b0;
    check("rsp_latency", c, resp_at);
    for (int h = 0; h <= hold; h++) begin
      check("rsp_valid", rsp_valid, 1);
      check("rsp_id", rsp_id, k);
      check("rsp_r", rsp_result_r, er);
      check("rsp_i", rsp_result_i, ei);
      check("rsp_error", rsp_error, exp_err);
      check("rsp_req_ready", req_ready, 0);
      check("rsp_busy", busy, 1);
      rsp_ready    = (h == hold);
      // A done pulse here lies outside WAIT and must be ignored.
      alu_done     = (c == d);
      alu_result_r = ~rr;
      alu_result_i = ~ri;
      cyc();
      c++;
    end
    alu_done  = 1'b0;
    rsp_ready = 1'b0;
    check("rsp_drop", rsp_valid, 0);
    check("idle_busy", busy, 0);
    model_last = k;
  endtask

  logic [18*NREQ-1:0] data;

  initial begin
    rst          = 1'b1;
    req_valid    = '0;
    req_data     = '0;
    alu_done     = 1'b0;
    alu_result_r = '0;
    alu_result_i = '0;
    rsp_ready    = 1'b0;
    model_last   = NREQ - 1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    req_valid = 4'b1111;
    #1;
    check("reset_req_ready_gated", req_ready, 0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Fairness: all requesters valid, ALU done after 3 cycles.
    for (int s = 0; s < NREQ; s++) data[s*18 +: 18] = rand_word(1'b1);
    for (int n = 0; n < 6; n++)
      do_op(4'b1111, data, 3, 8'($urandom), 8'($urandom), 0);

    // Single op from requester 1: {00,3,2,1,4}, done 4 cycles after start.
    for (int s = 0; s < NREQ; s++) data[s*18 +: 18] = rand_word(1'b0);
    data[1*18 +: 18] = 18'h03214;
    do_op(4'b0010, data, 4, 8'd4, 8'd6, 1);

    // Illegal opcode from requester 2; a stray done in RESP is ignored.
    data[2*18 +: 18] = {2'b11, 16'($urandom)};
    do_op(4'b0100, data, 1, 8'h55, 8'haa, 2);

    // Timeout with a late done during RESP.
    data[3*18 +: 18] = rand_word(1'b1);
    do_op(4'b1000, data, 20, 8'h7f, 8'h80, 5);

    // Done on the last WAIT cycle wins; one cycle later is a timeout.
    data[0*18 +: 18] = rand_word(1'b1);
    do_op(4'b0001, data, TIMEOUT, 8'h81, 8'h01, 0);
    do_op(4'b0001, data, TIMEOUT + 1, 8'h12, 8'h34, 0);

    // Backpressure with requesters 0 and 3 valid; 3 must follow 0.
    model_last = 0;
    data[3*18 +: 18] = rand_word(1'b1);
    do_op(4'b1000, data, 2, 8'h11, 8'h22, 0);
    do_op(4'b1001, data, 2, 8'hf0, 8'h0f, 5);
    do_op(4'b1001, data, 2, 8'h33, 8'h44, 0);

    // Randomized traffic.
    for (int n = 0; n < 24; n++) begin
      for (int s = 0; s < NREQ; s++) data[s*18 +: 18] = rand_word($urandom_range(0, 3) != 0);
      do_op(4'($urandom_range(1, 15)), data, $urandom_range(1, 18),
            8'($urandom), 8'($urandom), $urandom_range(0, 3));
    end

    // Reset two cycles after alu_start.
    data[2*18 +: 18] = rand_word(1'b1);
    req_data  = data;
    req_valid = 4'b0100;
    cyc();
    req_valid = '0;
    check("rst_test_alu_start", alu_start, 1);
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid_wait");
    cyc();
    rst = 1'b0;
    model_last = NREQ - 1;
    alu_done     = 1'b1;
    alu_result_r = 8'h5a;
    alu_result_i = 8'ha5;
    cyc();
    alu_done = 1'b0;
    for (int n = 0; n < 3; n++) begin
      check("post_rst_rsp_valid", rsp_valid, 0);
      check("post_rst_busy", busy, 0);
      cyc();
    end
    for (int s = 0; s < NREQ; s++) data[s*18 +: 18] = rand_word(1'b1);
    do_op(4'b1111, data, 2, 8'h21, 8'h43, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
